// File: rtl/spectral_flux_core.sv
// Streaming half-wave rectified spectral flux over N-bin frames, with per-band sums.
// Optional adaptive-threshold beat flag, built only when SPECTRAL_FLUX_BEAT_EN is defined.
module spectral_flux_core #(
  parameter int unsigned W               = 16,
  parameter int unsigned N               = 8,
  parameter int unsigned MAX_FLUX_LENGTH = 32,
  parameter int unsigned BEAT_SHIFT      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mag_valid,
  input  logic [W-1:0]               mag_sq,
  output logic [MAX_FLUX_LENGTH-1:0] flux_value,
  output logic [MAX_FLUX_LENGTH-1:0] flux_low,
  output logic [MAX_FLUX_LENGTH-1:0] flux_mid,
  output logic [MAX_FLUX_LENGTH-1:0] flux_high,
  output logic                       flux_valid,
  output logic                       frame_done,
  output logic                       beat_valid
);

  localparam int unsigned KW = $clog2(N);
  localparam int unsigned M  = MAX_FLUX_LENGTH;
  localparam logic [KW-1:0] QuarterIdx = KW'(N / 4);
  localparam logic [KW-1:0] HalfIdx    = KW'(N / 2);
  localparam logic [KW-1:0] LastIdx    = KW'(N - 1);

  function automatic logic [M-1:0] sat_add(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[M] ? {M{1'b1}} : s[M-1:0];
  endfunction

  logic [KW-1:0] k_q;
  logic [W-1:0]  prev_q [N];
  logic [M-1:0]  tot_q, low_q, mid_q, high_q;

  logic [W-1:0]  prev_k;
  logic [W-1:0]  diff;
  logic [M-1:0]  d_ext;
  logic          in_low, in_mid, in_high, last_bin;
  logic [M-1:0]  tot_n, low_n, mid_n, high_n;
  logic          beat_n;

  always_comb begin
    prev_k   = prev_q[k_q];
    diff     = (mag_sq > prev_k) ? (mag_sq - prev_k) : '0;
    d_ext    = M'(diff);
    in_low   = (k_q < QuarterIdx);
    in_mid   = !in_low && (k_q < HalfIdx);
    in_high  = !in_low && !in_mid;
    last_bin = (k_q == LastIdx);
    tot_n    = sat_add(tot_q, d_ext);
    low_n    = in_low  ? sat_add(low_q, d_ext)  : low_q;
    mid_n    = in_mid  ? sat_add(mid_q, d_ext)  : mid_q;
    high_n   = in_high ? sat_add(high_q, d_ext) : high_q;
  end

`ifdef SPECTRAL_FLUX_BEAT_EN
  // One extra bit so avg << 1 and the EMA update cannot overflow.
  logic [M:0] avg_q, avg_d, flux_ext;

  always_comb begin
    flux_ext = {1'b0, tot_n};
    beat_n   = flux_ext > (avg_q << 1);
    avg_d    = avg_q - (avg_q >> BEAT_SHIFT) + (flux_ext >> BEAT_SHIFT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avg_q <= '0;
    end else if (mag_valid && last_bin) begin
      avg_q <= avg_d;
    end
  end
`else
  assign beat_n = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q        <= '0;
      tot_q      <= '0;
      low_q      <= '0;
      mid_q      <= '0;
      high_q     <= '0;
      flux_value <= '0;
      flux_low   <= '0;
      flux_mid   <= '0;
      flux_high  <= '0;
      flux_valid <= 1'b0;
      frame_done <= 1'b0;
      beat_valid <= 1'b0;
      for (int i = 0; i < int'(N); i++) prev_q[i] <= '0;
    end else begin
      flux_valid <= mag_valid && last_bin;
      frame_done <= mag_valid && last_bin;
      beat_valid <= mag_valid && last_bin && beat_n;
      if (mag_valid) begin
        prev_q[k_q] <= mag_sq;
        if (last_bin) begin
          flux_value <= tot_n;
          flux_low   <= low_n;
          flux_mid   <= mid_n;
          flux_high  <= high_n;
          tot_q      <= '0;
          low_q      <= '0;
          mid_q      <= '0;
          high_q     <= '0;
          k_q        <= '0;
        end else begin
          tot_q  <= tot_n;
          low_q  <= low_n;
          mid_q  <= mid_n;
          high_q <= high_n;
          k_q    <= k_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spectral_flux_core.sv
// Directed self-checking bench for spectral_flux_core (N=8, W=16, BEAT_SHIFT=2).
// Beat expectations follow SPECTRAL_FLUX_BEAT_EN; without it beat_valid must stay 0.
module tb_spectral_flux_core;

  typedef logic [15:0] frame_t [8];

`ifdef SPECTRAL_FLUX_BEAT_EN
  localparam bit BeatEn = 1'b1;
`else
  localparam bit BeatEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        mag_valid;
  logic [15:0] mag_sq;
  logic [31:0] flux_value, flux_low, flux_mid, flux_high;
  logic        flux_valid, frame_done, beat_valid;

  int checks   = 0;
  int failures = 0;

  spectral_flux_core #(
    .W              (16),
    .N              (8),
    .MAX_FLUX_LENGTH(32),
    .BEAT_SHIFT     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mag_valid (mag_valid),
    .mag_sq    (mag_sq),
    .flux_value(flux_value),
    .flux_low  (flux_low),
    .flux_mid  (flux_mid),
    .flux_high (flux_high),
    .flux_valid(flux_valid),
    .frame_done(frame_done),
    .beat_valid(beat_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Leaves the caller at the negedge where the end-of-frame pulses are visible,
  // with mag_valid still high so a following frame can start back-to-back.
  task automatic drive_frame(input frame_t v, input int gap);
    for (int i = 0; i < 8; i++) begin
      mag_valid = 1'b1;
      mag_sq    = v[i];
      @(negedge clk);
      if (gap > 0 && i < 7) begin
        mag_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
  endtask

  task automatic do_reset();
    mag_valid = 1'b0;
    mag_sq    = '0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    mag_valid = 1'b0;
    mag_sq    = '0;
    reset     = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({flux_valid, frame_done, beat_valid} !== 3'b000) begin
        failures++;
        $display("FAIL reset_pulses cycle %0d: got %b required 000", c,
                 {flux_valid, frame_done, beat_valid});
      end
      checks++;
      if ({flux_value, flux_low, flux_mid, flux_high} !== 128'd0) begin
        failures++;
        $display("FAIL reset_values cycle %0d: got %0d/%0d/%0d/%0d required 0/0/0/0", c,
                 flux_value, flux_low, flux_mid, flux_high);
      end
    end
  endtask

  task automatic test_frames();
    frame_t      v;
    logic [31:0] exp_tot  [3] = '{32'd1600, 32'd60, 32'd4020};
    logic [31:0] exp_low  [3] = '{32'd400,  32'd0,  32'd580};
    logic [31:0] exp_mid  [3] = '{32'd400,  32'd0,  32'd1260};
    logic [31:0] exp_high [3] = '{32'd800,  32'd60, 32'd2180};
    logic        exp_beat [3] = '{1'b1, 1'b0, 1'b1};
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        case (f)
          0:       v[i] = 16'd200;
          1:       v[i] = 16'(100 + 20 * i);
          default: v[i] = (i % 3 == 0) ? 16'd100 : (i % 3 == 1) ? 16'd700 : 16'd1400;
        endcase
      end
      drive_frame(v, 0);
      checks++;
      if (flux_value !== exp_tot[f]) begin
        failures++;
        $display("FAIL frame%0d_total: got %0d required %0d", f + 1, flux_value, exp_tot[f]);
      end
      checks++;
      if ({flux_low, flux_mid, flux_high} !== {exp_low[f], exp_mid[f], exp_high[f]}) begin
        failures++;
        $display("FAIL frame%0d_bands: got %0d/%0d/%0d required %0d/%0d/%0d", f + 1,
                 flux_low, flux_mid, flux_high, exp_low[f], exp_mid[f], exp_high[f]);
      end
      checks++;
      if ({flux_valid, frame_done, beat_valid} !== {2'b11, exp_beat[f] & BeatEn}) begin
        failures++;
        $display("FAIL frame%0d_pulses: got %b required %b", f + 1,
                 {flux_valid, frame_done, beat_valid}, {2'b11, exp_beat[f] & BeatEn});
      end
      mag_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({flux_valid, frame_done, beat_valid} !== 3'b000 || flux_value !== exp_tot[f]) begin
        failures++;
        $display("FAIL frame%0d_hold: got pulses %b value %0d required 000 value %0d", f + 1,
                 {flux_valid, frame_done, beat_valid}, flux_value, exp_tot[f]);
      end
    end
  endtask

  task automatic test_gaps();
    frame_t v;
    do_reset();
    for (int i = 0; i < 8; i++) v[i] = 16'd200;
    drive_frame(v, 2);
    checks++;
    if ({flux_value, flux_low, flux_mid, flux_high} !== {32'd1600, 32'd400, 32'd400, 32'd800}) begin
      failures++;
      $display("FAIL gaps_values: got %0d/%0d/%0d/%0d required 1600/400/400/800",
               flux_value, flux_low, flux_mid, flux_high);
    end
    checks++;
    if ({flux_valid, frame_done, beat_valid} !== {2'b11, BeatEn}) begin
      failures++;
      $display("FAIL gaps_pulses: got %b required %b", {flux_valid, frame_done, beat_valid},
               {2'b11, BeatEn});
    end
    mag_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    frame_t v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mag_valid = 1'b1;
      mag_sq    = 16'd500;
      @(negedge clk);
    end
    mag_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({flux_valid, flux_value, flux_high} !== 65'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got valid %b value %0d high %0d required 0/0/0",
               flux_valid, flux_value, flux_high);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) v[i] = 16'd200;
    drive_frame(v, 0);
    checks++;
    if ({flux_value, flux_low, flux_mid, flux_high} !== {32'd1600, 32'd400, 32'd400, 32'd800}) begin
      failures++;
      $display("FAIL midreset_values: got %0d/%0d/%0d/%0d required 1600/400/400/800",
               flux_value, flux_low, flux_mid, flux_high);
    end
    checks++;
    if ({flux_valid, frame_done, beat_valid} !== {2'b11, BeatEn}) begin
      failures++;
      $display("FAIL midreset_pulses: got %b required %b", {flux_valid, frame_done, beat_valid},
               {2'b11, BeatEn});
    end
    mag_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    frame_t a, b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a[i] = 16'd200;
      b[i] = 16'd300;
    end
    drive_frame(a, 0);
    checks++;
    if (flux_value !== 32'd1600 || flux_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: got value %0d valid %b required 1600 valid 1",
               flux_value, flux_valid);
    end
    // Bin 0 of the second frame is presented while the first frame's pulses are high.
    drive_frame(b, 0);
    checks++;
    if ({flux_value, flux_low, flux_mid, flux_high} !== {32'd800, 32'd200, 32'd200, 32'd400}) begin
      failures++;
      $display("FAIL b2b_second_values: got %0d/%0d/%0d/%0d required 800/200/200/400",
               flux_value, flux_low, flux_mid, flux_high);
    end
    // 800 is not strictly greater than 2*avg = 800.
    checks++;
    if ({flux_valid, frame_done, beat_valid} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_second_pulses: got %b required 110",
               {flux_valid, frame_done, beat_valid});
    end
    mag_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (flux_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pulse_width: got %b required 0", flux_valid);
    end
  endtask

  initial begin
    reset     = 1'b0;
    mag_valid = 1'b0;
    mag_sq    = '0;
    test_reset();
    test_frames();
    test_gaps();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spectral_flux_core.md
# spectral_flux_core

Streaming spectral-flux onset detector for the audio beat-tracking chain. It sits after the FFT magnitude-squared stage. It compares each frame's N bin magnitudes against the previous frame and accumulates the positive differences (half-wave rectified flux), both in total and in three frequency bands. At each frame boundary it publishes the flux, plus an optional adaptive-threshold beat flag for the downstream tempo logic.

## Interface
- W, 16: width of each magnitude-squared sample.
- N, 8: bins per frame; power of two, ≥ 4.
- MAX_FLUX_LENGTH, 32: width of the flux accumulators and outputs.
- BEAT_SHIFT, 2: exponential-moving-average shift for the beat threshold.
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- mag_valid  in  1  qualifies mag_sq; one bin is consumed per cycle while it is high.
- mag_sq  in  W  unsigned magnitude-squared for the current bin.
- flux_value  out  MAX_FLUX_LENGTH  total positive flux of the last complete frame.
- flux_low / flux_mid / flux_high  out  MAX_FLUX_LENGTH  per-band flux of the last frame.
- flux_valid  out  1  one-cycle pulse when the flux outputs update.
- frame_done  out  1  one-cycle pulse, coincident with flux_valid.
- beat_valid  out  1  one-cycle beat flag, coincident with flux_valid.

## Operation
- Bin counter k runs 0..N-1 and advances only on mag_valid; idle cycles between bins are allowed and ignored.
- prev[N] register array holds the previous frame's magnitudes, read combinationally at index k.
- Per accepted bin:
  - d = (mag_sq > prev[k]) ? mag_sq − prev[k] : 0, zero-extended to MAX_FLUX_LENGTH.
  - prev[k] ← mag_sq.
  - d is added to the running total and to exactly one band accumulator.
- Band membership:
  - low: k < N/4.
  - mid: N/4 ≤ k < N/2.
  - high: k ≥ N/2.
- All accumulators saturate at 2^MAX_FLUX_LENGTH − 1; they never wrap.
- On acceptance of bin N−1:
  - The final sums, including d for bin N−1, are registered to flux_value/low/mid/high.
  - The running accumulators clear and k returns to 0.
- Outputs hold their value until the next frame completes.
- First frame after reset compares against prev = 0, so flux equals the sum of the magnitudes.
- Beat logic (see Configuration):
  - avg register is reset to 0.
  - At frame end, beat = flux > (avg << 1), using the avg value from before the update.
  - Then avg ← avg − (avg >> BEAT_SHIFT) + (flux >> BEAT_SHIFT).
  - All beat arithmetic is MAX_FLUX_LENGTH+1 bits wide, with no overflow.
- Reset (asynchronous, mid-frame included):
  - k = 0, accumulators = 0, prev[] = 0, avg = 0.
  - All outputs = 0; any partial frame is discarded.

## Timing
- Latency: flux outputs, flux_valid, frame_done and beat_valid all assert in the cycle after the clock edge that accepts bin N−1.
- Each pulse lasts exactly one cycle.
- No backpressure: every mag_valid cycle is consumed.
- Back-to-back frames are legal. If bin 0 of the next frame arrives in the same cycle the pulses are high, it is accepted normally into the cleared accumulators.
- A steady stream produces one update every N accepted bins.

## Configuration
- SPECTRAL_FLUX_BEAT_EN defined: the avg register and threshold compare are built, and beat_valid behaves as above.
- Undefined: no avg register is built and beat_valid is tied to 0. Flux outputs, flux_valid and frame_done are unchanged.

## Test plan
All scenarios use N=8, W=16, BEAT_SHIFT=2, with SPECTRAL_FLUX_BEAT_EN defined unless noted.
- Reset low for 5 cycles, then release with no input: all outputs read 0 and no pulses occur.
- Frame 1, flat 200 in all bins: flux_value=1600, low=400, mid=400, high=800, beat_valid=1; avg becomes 400.
- Frame 2, ramp 100+20·i (bins 100..240): flux_value=60, low=0, mid=0, high=60, beat_valid=0 (60 ≤ 800); avg becomes 315.
- Frame 3, pattern 100/700/1400 repeating by i%3: flux_value=4020, low=580, mid=1260, high=2180, beat_valid=1 (4020 > 630).
- Frame 1 fed with gaps (mag_valid low between bins) gives results identical to the contiguous case. Asserting reset after 4 bins, then sending a full frame of 200, yields flux_value=1600.
- Build without SPECTRAL_FLUX_BEAT_EN and repeat frames 1–3: flux values are identical and beat_valid stays 0.
